// File: rtl/fifo_umbrales_if.sv
// Handshake/data bundle between a fifo_umbrales instance and its producer/consumer.
// The master side drives requests and thresholds; the slave side is the FIFO.
interface fifo_umbrales_if #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int UMBRALES_L_H = 8
) ();
    logic [UMBRALES_L_H-1:0] umbral_LH_out;
    logic                    push;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    valid_out;
    logic [ADDR_WIDTH:0]     count;
    logic                    empty_fifo;
    logic                    full_fifo;
    logic                    almost_empty;
    logic                    almost_full;
    logic                    error;

    modport master (
        output umbral_LH_out, push, data_in, pop,
        input  data_out, valid_out, count, empty_fifo, full_fifo,
               almost_empty, almost_full, error
    );

    modport slave (
        input  umbral_LH_out, push, data_in, pop,
        output data_out, valid_out, count, empty_fifo, full_fifo,
               almost_empty, almost_full, error
    );
endinterface

// File: rtl/fifo_umbrales.sv
// Per-channel data FIFO with registered almost-empty / almost-full thresholds
// and a sticky overflow/underflow error flag.
module fifo_umbrales #(
    parameter int DATA_WIDTH   = 6,
    parameter int ADDR_WIDTH   = 3,
    parameter int UMBRALES_L_H = 8
) (
    input  logic              clk,
    input  logic              reset,
    fifo_umbrales_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int TW    = UMBRALES_L_H / 2;
    localparam int CMPW  = (TW > CW) ? TW : CW;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [TW-1:0]         alto_q, alto_d;
    logic [TW-1:0]         bajo_q, bajo_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  error_q, error_d;

    logic                  full, empty, rd_ok, wr_ok;
    logic [CMPW-1:0]       cnt_ext, alto_ext, bajo_ext;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        // A push at full still goes through when the same-cycle pop frees a slot.
        rd_ok       = bus.pop && !empty;
        wr_ok       = bus.push && (!full || rd_ok);
        error_d     = error_q | (bus.push & ~wr_ok) | (bus.pop & ~rd_ok);
        alto_d      = bus.umbral_LH_out[UMBRALES_L_H-1:TW];
        bajo_d      = bus.umbral_LH_out[TW-1:0];

        if (wr_ok) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_ok) begin
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alto_q      <= '0;
            bajo_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alto_q      <= alto_d;
            bajo_q      <= bajo_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

    // Storage is deliberately left out of reset; pointers/count define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cnt_ext  = CMPW'(count_q);
    assign alto_ext = CMPW'(alto_q);
    assign bajo_ext = CMPW'(bajo_q);

    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.count        = count_q;
    assign bus.error        = error_q;
    assign bus.empty_fifo   = empty;
    assign bus.full_fifo    = full;
    assign bus.almost_empty = (cnt_ext <= bajo_ext);
    assign bus.almost_full  = (alto_q != '0) && (cnt_ext >= alto_ext);
endmodule

// File: tb/tb_fifo_umbrales.sv
// Scenario-driven bench for fifo_umbrales with a queue-based reference model.
module tb_fifo_umbrales;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fifo_umbrales_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .UMBRALES_L_H(8)) bus ();

    fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(3), .UMBRALES_L_H(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: plain queue plus the observable registered outputs.
    logic [5:0] mq[$];
    logic       m_err;
    logic       m_vout;
    logic [5:0] m_dout;
    logic [7:0] m_thr;

    task automatic cyc(input logic r, input logic p, input logic [5:0] d, input logic po);
        int   n;
        logic rd, wr;
        logic [7:0] thr_in;
        reset       = r;
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = po;
        thr_in      = bus.umbral_LH_out;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_err  = 1'b0;
            m_vout = 1'b0;
            m_dout = '0;
            m_thr  = '0;
        end else begin
            n  = mq.size();
            rd = po && (n != 0);
            wr = p && ((n != 8) || rd);
            if ((po && !rd) || (p && !wr)) m_err = 1'b1;
            m_vout = rd;
            if (rd) m_dout = mq.pop_front();
            if (wr) mq.push_back(d);
            m_thr = thr_in;
        end
        reset    = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    task automatic test_reset();
        bus.umbral_LH_out = 8'h62;
        cyc(1'b1, 1'b1, 6'h11, 1'b0);
        cyc(1'b1, 1'b1, 6'h12, 1'b0);
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.empty_fifo !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty_fifo); end
        total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b exp=1", bus.almost_empty); end
        total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", bus.almost_full); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", bus.error); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.data_out !== 6'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.data_out); end
    endtask

    task automatic test_fill();
        bus.umbral_LH_out = 8'h62;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b1, 6'(k), 1'b0);
            total++; if (bus.count !== 4'(k)) begin bad++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, bus.count, k); end
            total++; if (bus.almost_empty !== (k <= 2)) begin bad++; $display("FAIL fill_aempty k=%0d got=%b exp=%b", k, bus.almost_empty, (k <= 2)); end
            total++; if (bus.almost_full !== (k >= 6)) begin bad++; $display("FAIL fill_afull k=%0d got=%b exp=%b", k, bus.almost_full, (k >= 6)); end
            total++; if (bus.full_fifo !== (k == 8)) begin bad++; $display("FAIL fill_full k=%0d got=%b exp=%b", k, bus.full_fifo, (k == 8)); end
        end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL fill_error_pre got=%b exp=0", bus.error); end
        cyc(1'b0, 1'b1, 6'h09, 1'b0);
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL overflow_error got=%b exp=1", bus.error); end
        total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL overflow_count got=%0d exp=8", bus.count); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b0, 6'h00, 1'b1);
            total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL drain_valid i=%0d got=%b exp=1", i, bus.valid_out); end
            total++; if (bus.data_out !== 6'(i)) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, bus.data_out, 6'(i)); end
        end
        total++; if (bus.empty_fifo !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", bus.empty_fifo); end
        cyc(1'b0, 1'b0, 6'h00, 1'b0);
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL drain_idle_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.data_out !== 6'h08) begin bad++; $display("FAIL drain_hold_data got=%h exp=08", bus.data_out); end
    endtask

    task automatic test_underflow();
        cyc(1'b1, 1'b0, 6'h00, 1'b0);
        cyc(1'b0, 1'b0, 6'h00, 1'b1);
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL under_valid got=%b exp=0", bus.valid_out); end
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL under_count got=%0d exp=0", bus.count); end
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL under_error got=%b exp=1", bus.error); end
        cyc(1'b1, 1'b0, 6'h00, 1'b0);
        cyc(1'b0, 1'b1, 6'h33, 1'b1);
        total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL pp_empty_count got=%0d exp=1", bus.count); end
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL pp_empty_error got=%b exp=1", bus.error); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL pp_empty_valid got=%b exp=0", bus.valid_out); end
        cyc(1'b0, 1'b0, 6'h00, 1'b1);
        total++; if (bus.data_out !== 6'h33) begin bad++; $display("FAIL pp_empty_data got=%h exp=33", bus.data_out); end
    endtask

    task automatic test_full_simul();
        logic [5:0] w [8];
        cyc(1'b1, 1'b0, 6'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w[i] = 6'($urandom);
            cyc(1'b0, 1'b1, w[i], 1'b0);
        end
        cyc(1'b0, 1'b1, 6'h2A, 1'b1);
        total++; if (bus.data_out !== w[0]) begin bad++; $display("FAIL fsim_data got=%h exp=%h", bus.data_out, w[0]); end
        total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL fsim_valid got=%b exp=1", bus.valid_out); end
        total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL fsim_count got=%0d exp=8", bus.count); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL fsim_error got=%b exp=0", bus.error); end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 6'h00, 1'b1);
            if (i < 7) begin
                total++; if (bus.data_out !== w[i+1]) begin bad++; $display("FAIL fsim_drain i=%0d got=%h exp=%h", i, bus.data_out, w[i+1]); end
            end else begin
                total++; if (bus.data_out !== 6'h2A) begin bad++; $display("FAIL fsim_last got=%h exp=2a", bus.data_out); end
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 6'h00, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 6'($urandom), 1'b0);
        total++; if (bus.count !== 4'd5) begin bad++; $display("FAIL rmid_pre got=%0d exp=5", bus.count); end
        cyc(1'b1, 1'b1, 6'h3F, 1'b1);
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", bus.count); end
        total++; if (bus.empty_fifo !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%b exp=1", bus.empty_fifo); end
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus.valid_out); end
        cyc(1'b0, 1'b1, 6'h15, 1'b0);
        cyc(1'b0, 1'b0, 6'h00, 1'b1);
        total++; if (bus.data_out !== 6'h15) begin bad++; $display("FAIL rmid_data got=%h exp=15", bus.data_out); end
        total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL rmid_rvalid got=%b exp=1", bus.valid_out); end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b0, 6'h00, 1'b0);
        cyc(1'b0, 1'b1, 6'h01, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 6'(i + 2), 1'b1);
            total++; if (bus.valid_out !== 1'b1 || bus.data_out !== 6'(i + 1)) begin
                bad++; $display("FAIL b2b i=%0d got=%b/%h exp=1/%h", i, bus.valid_out, bus.data_out, 6'(i + 1));
            end
            total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL b2b_count i=%0d got=%0d exp=1", i, bus.count); end
        end
    endtask

    task automatic test_random();
        int ppush, ppop, sz, bajo, alto;
        logic e_ae, e_af;
        cyc(1'b1, 1'b0, 6'h00, 1'b0);
        for (int c = 0; c < 600; c++) begin
            ppush = ((c / 50) % 2 == 0) ? 80 : 25;
            ppop  = 100 - ppush;
            if ($urandom_range(0, 15) == 0) bus.umbral_LH_out = 8'($urandom);
            cyc(($urandom_range(0, 127) == 0), ($urandom_range(0, 99) < ppush),
                6'($urandom), ($urandom_range(0, 99) < ppop));
            sz   = mq.size();
            bajo = int'(m_thr[3:0]);
            alto = int'(m_thr[7:4]);
            e_ae = (sz <= bajo);
            e_af = (alto != 0) && (sz >= alto);
            total++; if (bus.count !== 4'(sz)) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.count, sz); end
            total++; if (bus.valid_out !== m_vout || (m_vout && bus.data_out !== m_dout)) begin
                bad++; $display("FAIL rnd_read c=%0d got=%b/%h exp=%b/%h", c, bus.valid_out, bus.data_out, m_vout, m_dout);
            end
            total++; if (bus.error !== m_err) begin bad++; $display("FAIL rnd_error c=%0d got=%b exp=%b", c, bus.error, m_err); end
            total++; if ({bus.empty_fifo, bus.full_fifo, bus.almost_empty, bus.almost_full} !== {(sz == 0), (sz == 8), e_ae, e_af}) begin
                bad++; $display("FAIL rnd_flags c=%0d thr=%h got=%b%b%b%b exp=%b%b%b%b", c, m_thr,
                    bus.empty_fifo, bus.full_fifo, bus.almost_empty, bus.almost_full, (sz == 0), (sz == 8), e_ae, e_af);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        bus.push          = 1'b0;
        bus.pop           = 1'b0;
        bus.data_in       = '0;
        bus.umbral_LH_out = '0;
        mq.delete();
        m_err  = 1'b0;
        m_vout = 1'b0;
        m_dout = '0;
        m_thr  = '0;
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_full_simul();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Per-channel data FIFO with programmable almost-empty / almost-full flags. Eight instances sit upstream and downstream of the flow-control FSM. Each one feeds its `empty_fifo` flag to the FSM and consumes the packed low/high thresholds `umbral_LH_out` that the FSM latches during initialization. The almost flags drive the pause/resume logic of the switch datapath.

## Interface
- `DATA_WIDTH`, default 6, width of each stored word.
- `ADDR_WIDTH`, default 3, pointer width; depth = 2^ADDR_WIDTH = 8.
- `UMBRALES_L_H`, default 8, width of the packed threshold bus.
  - Low half = umbral bajo (almost-empty).
  - High half = umbral alto (almost-full).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `umbral_LH_out`  in  UMBRALES_L_H  packed thresholds from the FSM.
  - `[UMBRALES_L_H-1:UMBRALES_L_H/2]` = alto.
  - `[UMBRALES_L_H/2-1:0]` = bajo.
- `push`  in  1  write request.
- `data_in`  in  DATA_WIDTH  word written when `push` is accepted.
- `pop`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read data.
- `valid_out`  out  1  `data_out` holds a word popped on the previous edge.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..8.
- `empty_fifo`  out  1  count == 0; goes to the FSM.
- `full_fifo`  out  1  count == 8.
- `almost_empty`  out  1  count <= registered bajo.
- `almost_full`  out  1  registered alto != 0 and count >= registered alto.
- `error`  out  1  sticky overflow/underflow flag.

## Operation
Storage:
- 8-entry register array with write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_WIDTH bits.
- Pointers wrap 7 -> 0 naturally.
- `count` is a separate ADDR_WIDTH+1 register.

Acceptance, evaluated on the pre-edge `count`:
- A write is accepted iff `push` and (not full, or `pop` is also accepted this cycle).
- A read is accepted iff `pop` and count != 0.
- Simultaneous push+pop at count 8: both are performed, count stays 8, FIFO order is preserved.
- Simultaneous push+pop at count 0: the write is performed and the read is rejected. This counts as an underflow; count becomes 1 and `valid_out` = 0.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither occur.

Errors:
- A rejected push (overflow) or rejected pop (underflow) sets `error`.
- `error` remains 1 until reset. Rejected operations modify no other state.

Thresholds:
- `umbral_LH_out` is registered every cycle into the internal `umbral_alto` / `umbral_bajo` registers.
- The flags use only the registered copies.
- alto = 0 disables `almost_full`.
- alto > 8 never asserts `almost_full`.
- bajo >= 8 keeps `almost_empty` permanently at 1.

Read data:
- On an accepted read, `data_out` <= mem[rd_ptr] and `valid_out` <= 1.
- Otherwise `valid_out` <= 0 and `data_out` holds its value.

Status flags (`empty_fifo`, `full_fifo`, `almost_*`) are combinational from the registered `count` and thresholds. No combinational path exists from `push`/`pop` to any output.

Reset values:
- Pointers = 0, `count` = 0, thresholds = 0.
- `data_out` = 0, `valid_out` = 0, `error` = 0.
- `empty_fifo` = 1, `full_fifo` = 0, `almost_empty` = 1, `almost_full` = 0.
- Memory contents are not cleared.

## Timing
- Write latency: a push accepted at edge N updates `count` and flags after edge N. The word is readable by a pop at edge N+1.
- Read latency: a pop accepted at edge N presents `data_out` / `valid_out` = 1 during cycle N..N+1.
- Threshold latency: a change on `umbral_LH_out` before edge N affects the almost flags after edge N.
- Reset mid-operation: reset asserted at edge N empties the FIFO at edge N regardless of `push`/`pop`. Stored words are lost, and `valid_out` = 0 after edge N.
- Back-to-back push/pop is sustained every cycle with no bubble.

## Test plan
- Reset: assert `reset` for 2 cycles with `push` = 1 -> after release, `count` = 0, `empty_fifo` = 1, `almost_empty` = 1, `almost_full` = 0, `error` = 0, `valid_out` = 0.
- Fill with `umbral_LH_out` = 8'h62: push 0x01..0x08 on consecutive cycles.
  - `almost_empty` drops after the 3rd push.
  - `almost_full` rises after the 6th push.
  - `full_fifo` rises after the 8th push.
  - A 9th push (0x09) sets `error`, and `count` stays 8.
- Drain: pop 8 times -> `data_out` = 0x01..0x08 in order, each with `valid_out` = 1 one edge after its pop; `empty_fifo` = 1 after the 8th pop.
- Underflow: pop on empty -> `valid_out` = 0, `count` = 0, `error` = 1. Push+pop on empty -> `count` = 1, `error` = 1.
- Full simultaneous: at count 8, push 0x2A with pop -> `data_out` = oldest word, `count` = 8, `error` unchanged. 0x2A emerges 8th in the subsequent drain.
- Reset mid-fill: at count 5, pulse `reset` -> `count` = 0, `empty_fifo` = 1. A following push 0x15 then pop returns 0x15.
